wos_stream_filter: RTL and testbench

//  Parametrised weighted order-statistic (WOS) filter engine with a DMA-style controller.
//  On start it streams len samples from a sync source ROM through an N-tap window and writes
//  one filtered sample per input to a result RAM. Runtime rank and per-tap weights generalise
//  the fixed-rank median path. Sits between source ROM and result RAM, below board-level glue.

---
 rtl/wos_pkg.sv | 23 ++
 rtl/wos_rank_core.sv | 91 +++++++++
 rtl/wos_stream_filter.sv | 212 +++++++++++++++++++++
 tb/tb_wos_stream_filter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wos_pkg.sv
// Shared types and constants for the weighted order-statistic stream filter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: controller state encoding, rank/total-weight width helper, result pipeline depth.
package wos_pkg;

  // Controller states. IDLE is all-zero so the reset value is also the idle encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wos_state_e;

  // Cycles from a source address being issued to its result write:
  // ROM read (1) + window shift (1) + rank-core output register (1).
  localparam int PIPE_LAT = 3;

  // Width that holds any rank and the largest possible total weight N*(2**W_BITS-1).
  function automatic int rank_bits_f(input int n_taps, input int w_bits);
    return $clog2(n_taps * ((1 << w_bits) - 1) + 1);
  endfunction

endpackage

// File: rtl/wos_rank_core.sv
// Weighted order-statistic selector over N window taps with one output register.
// Latency: 1 cycle from taps_i/en_i to sel_o. Backpressure: none, loads whenever en_i is high.
// Ports: clk_i/rst_i (async active-high), en_i load enable, taps_i (tap 0 in low bits),
//        weights_i (W_BITS per tap), rank_i (0 = minimum), sel_o registered selected sample.
module wos_rank_core
  import wos_pkg::*;
#(
  parameter int N         = 3,
  parameter int DATA_BITS = 8,
  parameter int W_BITS    = 2,
  parameter int RANK_BITS = rank_bits_f(N, W_BITS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [N*DATA_BITS-1:0] taps_i,
  input  logic [N*W_BITS-1:0]    weights_i,
  input  logic [RANK_BITS-1:0]   rank_i,
  output logic [DATA_BITS-1:0]   sel_o
);

  logic [DATA_BITS-1:0] x    [N];
  logic [RANK_BITS-1:0] w    [N];
  logic [RANK_BITS-1:0] cum  [N];
  logic                 qual [N];
  logic [RANK_BITS-1:0] total;
  logic [RANK_BITS-1:0] eff_rank;
  logic [DATA_BITS-1:0] sel_d;
  logic [DATA_BITS-1:0] sel_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x[i] = taps_i[i*DATA_BITS +: DATA_BITS];
      w[i] = RANK_BITS'(weights_i[i*W_BITS +: W_BITS]);
    end
  end

  // Total weight cannot overflow: RANK_BITS is sized for every weight at maximum.
  always_comb begin
    total = '0;
    for (int i = 0; i < N; i++) begin
      total = total + w[i];
    end
  end

  // Ranks past the end of the multiset select its largest element.
  // When total is zero this wraps, but the result is forced to zero below.
  assign eff_rank = (rank_i >= total) ? (total - RANK_BITS'(1)) : rank_i;

  // For each tap j: weight of all taps not greater than x[j]. Tap j is a
  // candidate when that cumulative weight passes the effective rank.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      logic [RANK_BITS-1:0] acc;
      acc = '0;
      for (int i = 0; i < N; i++) begin
        if (x[i] <= x[j]) begin
          acc = acc + w[i];
        end
      end
      cum[j]  = acc;
      qual[j] = (acc > eff_rank);
    end
  end

  // Smallest candidate value is the weighted order statistic.
  always_comb begin
    logic                 found;
    logic [DATA_BITS-1:0] best;
    found = 1'b0;
    best  = '0;
    for (int j = 0; j < N; j++) begin
      if (qual[j] && (!found || (x[j] < best))) begin
        found = 1'b1;
        best  = x[j];
      end
    end
    sel_d = (total == '0) ? '0 : best;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q <= '0;
    end else if (en_i) begin
      sel_q <= sel_d;
    end
  end

  assign sel_o = sel_q;

endmodule

// File: rtl/wos_stream_filter.sv
// DMA-style WOS filter: streams len samples from a sync ROM through an N-tap window into a result RAM.
// Latency: result k written exactly 3 cycles after src_addr_o = k. Backpressure: none; one sample per cycle.
// Ports: start_i/abort_i control, len_i/rank_i/weights_i config (latched on accepted start),
//        src_addr_o/src_data_i ROM side, res_we_o/res_addr_o/res_data_o RAM side, busy_o/done_o/wt_err_o status.
module wos_stream_filter
  import wos_pkg::*;
#(
  parameter int N         = 3,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8,
  parameter int W_BITS    = 2,
  parameter int RANK_BITS = rank_bits_f(N, W_BITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDR_BITS-1:0] len_i,
  input  logic [RANK_BITS-1:0] rank_i,
  input  logic [N*W_BITS-1:0]  weights_i,
  output logic [ADDR_BITS-1:0] src_addr_o,
  input  logic [DATA_BITS-1:0] src_data_i,
  output logic                 res_we_o,
  output logic [ADDR_BITS-1:0] res_addr_o,
  output logic [DATA_BITS-1:0] res_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wt_err_o
);

  wos_state_e state_q, state_d;

  logic [ADDR_BITS-1:0]   len_q;
  logic [RANK_BITS-1:0]   rank_q;
  logic [N*W_BITS-1:0]    wts_q;
  logic                   wt_err_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [PIPE_LAT-1:0]    vld_q;            // bit 0 = address issued last cycle
  logic [ADDR_BITS-1:0]   adr_q [PIPE_LAT];
  logic [DATA_BITS-1:0]   taps_q [N];       // tap 0 = newest sample
  logic [N*DATA_BITS-1:0] taps_flat;
  logic [RANK_BITS-1:0]   wsum_in;

  logic accept;
  logic flush;
  logic issue;
  logic last_issue;

  // abort takes priority over a simultaneous start in IDLE.
  assign accept     = (state_q == ST_IDLE) && start_i && !abort_i;
  assign flush      = (state_q != ST_IDLE) && abort_i;
  assign last_issue = (addr_q == (len_q - ADDR_BITS'(1)));

  // ---------------- controller: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- controller: next state ----------------
  // A zero-length job goes through DRAIN (pipeline already empty) so busy is
  // high for one cycle and done follows two cycles after the start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (len_i == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once only the final write is left in the last stage.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (!vld_q[0] && !vld_q[1]) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- controller: outputs ----------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    issue  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        busy_o = 1'b1;
        issue  = 1'b1;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Total of the incoming weights, used to flag an empty multiset at start.
  always_comb begin
    wsum_in = '0;
    for (int i = 0; i < N; i++) begin
      wsum_in = wsum_in + RANK_BITS'(weights_i[i*W_BITS +: W_BITS]);
    end
  end

  // Job configuration and source address counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q    <= '0;
      rank_q   <= '0;
      wts_q    <= '0;
      wt_err_q <= 1'b0;
      addr_q   <= '0;
    end else if (accept) begin
      len_q    <= len_i;
      rank_q   <= rank_i;
      wts_q    <= weights_i;
      wt_err_q <= (wsum_in == '0);
      addr_q   <= '0;
    end else if (issue) begin
      addr_q <= addr_q + ADDR_BITS'(1);
    end
  end

  // Valid and address pipeline alongside the ROM read / window / rank stages.
  // abort drops everything in flight, so no further writes appear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        adr_q[i] <= '0;
      end
    end else begin
      vld_q    <= flush ? '0 : {vld_q[PIPE_LAT-2:0], issue};
      adr_q[0] <= addr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  // Window shift register. The first sample of a job fills every tap so the
  // leading outputs see s[<0] = s[0].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        taps_q[i] <= '0;
      end
    end else if (vld_q[0]) begin
      if (adr_q[0] == '0) begin
        for (int i = 0; i < N; i++) begin
          taps_q[i] <= src_data_i;
        end
      end else begin
        taps_q[0] <= src_data_i;
        for (int i = 1; i < N; i++) begin
          taps_q[i] <= taps_q[i-1];
        end
      end
    end
  end

  always_comb begin
    taps_flat = '0;
    for (int i = 0; i < N; i++) begin
      taps_flat[i*DATA_BITS +: DATA_BITS] = taps_q[i];
    end
  end

  wos_rank_core #(
    .N         (N),
    .DATA_BITS (DATA_BITS),
    .W_BITS    (W_BITS),
    .RANK_BITS (RANK_BITS)
  ) u_rank_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (vld_q[1]),
    .taps_i    (taps_flat),
    .weights_i (wts_q),
    .rank_i    (rank_q),
    .sel_o     (res_data_o)
  );

  assign src_addr_o = addr_q;
  assign res_we_o   = vld_q[PIPE_LAT-1];
  assign res_addr_o = adr_q[PIPE_LAT-1];
  assign wt_err_o   = wt_err_q;

endmodule

// File: tb/tb_wos_stream_filter.sv
// Bench for wos_stream_filter: directed jobs against a sorted-multiset reference model.
// Latency: checks every result write for address, data and exact cycle. Backpressure: n/a.
// A negedge compare process consumes the expected-write queue; tasks check control timing.
module tb_wos_stream_filter;

  localparam int N  = 3;
  localparam int DB = 8;
  localparam int AB = 8;
  localparam int WB = 2;
  localparam int RB = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic [AB-1:0] len     = '0;
  logic [RB-1:0] rank    = '0;
  logic [N*WB-1:0] weights = '0;
  logic [AB-1:0] src_addr;
  logic [DB-1:0] src_data;
  logic          res_we;
  logic [AB-1:0] res_addr;
  logic [DB-1:0] res_data;
  logic          busy;
  logic          done;
  logic          wt_err;

  logic [DB-1:0] rom [256];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  wos_stream_filter #(
    .N         (N),
    .DATA_BITS (DB),
    .ADDR_BITS (AB),
    .W_BITS    (WB),
    .RANK_BITS (RB)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .len_i      (len),
    .rank_i     (rank),
    .weights_i  (weights),
    .src_addr_o (src_addr),
    .src_data_i (src_data),
    .res_we_o   (res_we),
    .res_addr_o (res_addr),
    .res_data_o (res_data),
    .busy_o     (busy),
    .done_o     (done),
    .wt_err_o   (wt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source ROM: data one cycle after the address.
  always @(posedge clk) src_data <= rom[src_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: expand each tap by its weight, sort, index by clamped rank.
  function automatic int wos_ref(input int x0, input int x1, input int x2,
                                 input int w0, input int w1, input int w2, input int r);
    int ms[$];
    int xs[3];
    int ws[3];
    xs = '{x0, x1, x2};
    ws = '{w0, w1, w2};
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < ws[i]; k++) ms.push_back(xs[i]);
    if (ms.size() == 0) return 0;
    ms.sort();
    if (r >= ms.size()) r = ms.size() - 1;
    return ms[r];
  endfunction

  // Model value for output k of a job (window with edge replication).
  function automatic int model_out(input int k, input int r, input int w0, input int w1, input int w2);
    int xv[3];
    for (int i = 0; i < 3; i++) xv[i] = rom[(k - i < 0) ? 0 : k - i];
    return wos_ref(xv[0], xv[1], xv[2], w0, w1, w2, r);
  endfunction

  // Every write is matched against the next expected one.
  always @(negedge clk) begin : compare
    exp_t e;
    if (!rst && res_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_write: addr %0d data %0d, no write expected (cycle %0d)", res_addr, res_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("res_addr", res_addr, e.addr);
        chk("res_data", res_data, e.data);
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  // Runs one job starting at a negedge; returns at a negedge.
  task automatic run_job(input int n, input int r, input int w0, input int w1, input int w2,
                         input bit poke, input bit use_pin, input int pin[5]);
    int c;
    int v;
    bit got;
    c = cyc;
    for (int k = 0; k < n; k++) begin
      v = model_out(k, r, w0, w1, w2);
      if (use_pin && k < 5) chk($sformatf("model_pin[%0d]", k), v, pin[k]);
      exp_q.push_back('{k, v, c + 4 + k});
    end
    len     = AB'(n);
    rank    = RB'(r);
    weights = {2'(w2), 2'(w1), 2'(w0)};
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    got = 1'b0;
    for (int g = 0; g < n + 20 && !got; g++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        // A second start mid-job with different config must be ignored.
        if (poke && cyc == c + 3) begin
          start = 1'b1; len = 8'd2; rank = '0; weights = '0;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    if (got) begin
      chk("done_cycle", cyc, (n == 0) ? c + 2 : c + n + 4);
      chk("busy_at_done", busy, 0);
      chk("wt_err", wt_err, (w0 + w1 + w2 == 0) ? 1 : 0);
      @(negedge clk);
      chk("done_pulse_width", done, 0);
    end
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    bit got;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 8'd10; rom[1] = 8'd50; rom[2] = 8'd20; rom[3] = 8'd80; rom[4] = 8'd30;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_res_we", res_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wt_err", wt_err, 0);
    chk("rst_src_addr", src_addr, 0);
    chk("rst_res_data", res_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_job(5, 1, 1, 1, 1, 1'b0, 1'b1, '{10, 10, 20, 50, 30});   // median
    run_job(5, 0, 1, 0, 0, 1'b0, 1'b1, '{10, 50, 20, 80, 30});   // identity
    run_job(5, 7, 1, 1, 1, 1'b1, 1'b1, '{10, 50, 50, 80, 80});   // clamped rank = running max, start poked
    run_job(5, 1, 0, 0, 0, 1'b0, 1'b1, '{0, 0, 0, 0, 0});        // zero weights
    run_job(5, 1, 2, 1, 0, 1'b0, 1'b1, '{10, 50, 20, 80, 30});   // clears wt_err
    run_job(0, 1, 1, 1, 1, 1'b0, 1'b0, '{0, 0, 0, 0, 0});        // empty job

    // start and abort together in IDLE: not accepted.
    len = 8'd5; rank = 4'd1; weights = {2'd1, 2'd1, 2'd1};
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    got = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) got = 1'b1;
    end
    chk("start_abort_idle", got, 0);

    // Abort mid-RUN after two writes.
    c = cyc;
    exp_q.push_back('{0, model_out(0, 1, 1, 1, 1), c + 4});
    exp_q.push_back('{1, model_out(1, 1, 1, 1, 1), c + 5});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("abort_no_done", got, 0);
    chk("abort_writes_left", exp_q.size(), 0);
    exp_q.delete();

    // Reset mid-RUN after two writes: outputs drop without waiting for a clock.
    c = cyc;
    exp_q.push_back('{0, model_out(0, 1, 1, 1, 1), c + 4});
    exp_q.push_back('{1, model_out(1, 1, 1, 1, 1), c + 5});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_res_we", res_we, 0);
    chk("midrun_rst_busy", busy, 0);
    @(negedge clk);
    chk("midrun_rst_writes_left", exp_q.size(), 0);
    chk("midrun_rst_src_addr", src_addr, 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);

    run_job(5, 1, 1, 1, 1, 1'b0, 1'b1, '{10, 10, 20, 50, 30});   // recovery after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
